// File: rtl/add_multi_pipe_if.sv
// Operand/result bundle for add_multi_pipe: stall enable, tagged operand input,
// tagged sum and carry-out output.
interface add_multi_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 3
);
  logic                     en;
  logic                     in_valid;
  logic [NUM_OPS*WIDTH-1:0] in_ops;
  logic                     out_valid;
  logic [WIDTH-1:0]         o;
  logic [1:0]               out_cy;

  modport master (
    output en, in_valid, in_ops,
    input  out_valid, o, out_cy
  );

  modport slave (
    input  en, in_valid, in_ops,
    output out_valid, o, out_cy
  );
endinterface

// File: rtl/add_multi_pipe.sv
// Pipelined multi-operand adder: the carry chain is cut into SPLIT chunks, one
// chunk per stage, with operand chunks skewed forward and valid tagging.
module add_multi_pipe #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 3,
  parameter int SPLIT   = 2
) (
  input logic            CLK,
  input logic            RST,
  add_multi_pipe_if.slave bus
);
  localparam int CW = WIDTH / SPLIT;

  logic          vld_q  [SPLIT];
  logic [1:0]    cy_q   [SPLIT];
  logic [CW-1:0] res_q  [SPLIT][SPLIT];
  logic [CW-1:0] skew_q [SPLIT][NUM_OPS][SPLIT];
  logic [CW+1:0] tsum   [SPLIT];

  // Stage s adds chunk s of every operand plus the carry out of stage s-1;
  // stage 0 takes its chunks straight from the input bus.
  always_comb begin
    tsum[0] = '0;
    for (int unsigned k = 0; k < NUM_OPS; k++) begin
      tsum[0] = tsum[0] + {2'b00, bus.in_ops[k*WIDTH +: CW]};
    end
    for (int unsigned s = 1; s < SPLIT; s++) begin
      tsum[s] = {{CW{1'b0}}, cy_q[s-1]};
      for (int unsigned k = 0; k < NUM_OPS; k++) begin
        tsum[s] = tsum[s] + {2'b00, skew_q[s-1][k][s]};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned s = 0; s < SPLIT; s++) begin
        vld_q[s] <= 1'b0;
        cy_q[s]  <= '0;
        for (int unsigned c = 0; c < SPLIT; c++) begin
          res_q[s][c] <= '0;
          for (int unsigned k = 0; k < NUM_OPS; k++) begin
            skew_q[s][k][c] <= '0;
          end
        end
      end
    end else if (bus.en) begin
      vld_q[0] <= bus.in_valid;
      cy_q[0]  <= tsum[0][CW+1:CW];
      for (int unsigned c = 0; c < SPLIT; c++) begin
        res_q[0][c] <= (c == 0) ? tsum[0][CW-1:0] : '0;
        for (int unsigned k = 0; k < NUM_OPS; k++) begin
          skew_q[0][k][c] <= bus.in_ops[k*WIDTH + c*CW +: CW];
        end
      end
      // Later stages shift operands and finished chunks along, replacing only their own chunk.
      for (int unsigned s = 1; s < SPLIT; s++) begin
        vld_q[s] <= vld_q[s-1];
        cy_q[s]  <= tsum[s][CW+1:CW];
        for (int unsigned c = 0; c < SPLIT; c++) begin
          res_q[s][c] <= (c == s) ? tsum[s][CW-1:0] : res_q[s-1][c];
          for (int unsigned k = 0; k < NUM_OPS; k++) begin
            skew_q[s][k][c] <= skew_q[s-1][k][c];
          end
        end
      end
    end
  end

  always_comb begin
    bus.o = '0;
    for (int unsigned c = 0; c < SPLIT; c++) begin
      bus.o[c*CW +: CW] = res_q[SPLIT-1][c];
    end
  end

  assign bus.out_valid = vld_q[SPLIT-1];
  assign bus.out_cy    = cy_q[SPLIT-1];
endmodule
